hamming_word_assembler: RTL

HAMMING_WORD_ASSEMBLER -- requirements
Module: hamming_word_assembler

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming74_correct.sv | 35 +++
 rtl/hamming_word_assembler.sv | 113 +++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) word assembler.
// Code positions are 1-based, as in the classic (7,4) layout p1,p2,d1,p3,d2,d3,d4.
package hamming_pkg;

   localparam int unsigned CW_W  = 7;
   localparam int unsigned NIB_W = 4;

   localparam int unsigned POS_P1 = 1;
   localparam int unsigned POS_P2 = 2;
   localparam int unsigned POS_D1 = 3;
   localparam int unsigned POS_P3 = 4;
   localparam int unsigned POS_D2 = 5;
   localparam int unsigned POS_D3 = 6;
   localparam int unsigned POS_D4 = 7;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/hamming74_correct.sv
// Combinational single-error correction of one Hamming(7,4) codeword.
// cw[k] holds code position k+1; nibble is {d1,d2,d3,d4} in index order.
module hamming74_correct
   import hamming_pkg::*;
(
   input  logic [0:CW_W-1]  cw,
   output logic [0:NIB_W-1] nibble,
   output logic             corrected
);

   logic            c1;
   logic            c2;
   logic            c3;
   logic [2:0]      syn;
   logic [0:CW_W-1] fixed;

   always_comb begin
      c1  = cw[POS_P1-1] ^ cw[POS_D1-1] ^ cw[POS_D2-1] ^ cw[POS_D4-1];
      c2  = cw[POS_P2-1] ^ cw[POS_D1-1] ^ cw[POS_D3-1] ^ cw[POS_D4-1];
      c3  = cw[POS_P3-1] ^ cw[POS_D2-1] ^ cw[POS_D3-1] ^ cw[POS_D4-1];
      syn = {c3, c2, c1};

      // The syndrome value is the 1-based position of the flipped bit.
      fixed = cw;
      for (int unsigned k = 0; k < CW_W; k++) begin
         if (syn == 3'(k + 1)) begin
            fixed[k] = ~cw[k];
         end
      end

      corrected = (syn != 3'd0);
      nibble    = {fixed[POS_D1-1], fixed[POS_D2-1], fixed[POS_D3-1], fixed[POS_D4-1]};
   end

endmodule

// File: rtl/hamming_word_assembler.sv
// Assembles N_NIB corrected Hamming(7,4) nibbles into one word with a
// valid/ready handshake on both sides and a saturating correction counter.
module hamming_word_assembler
   import hamming_pkg::*;
#(
   parameter int unsigned N_NIB = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [0:CW_W-1]        cw_in,
   input  logic                   cw_valid,
   output logic                   cw_ready,
   input  logic                   sync,
   output logic [0:NIB_W*N_NIB-1] word_out,
   output logic                   word_valid,
   input  logic                   out_ready,
   output logic                   word_err,
   output logic [7:0]             corr_cnt
);

   localparam int unsigned       WORD_W   = NIB_W * N_NIB;
   localparam int unsigned       CNT_W    = (N_NIB > 1) ? $clog2(N_NIB) : 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_NIB - 1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               err_q;
   logic               err_d;
   logic [0:WORD_W-1]  word_q;
   logic [0:WORD_W-1]  word_d;
   logic [7:0]         corr_q;
   logic [7:0]         corr_d;
   logic               rdy_q;
   logic               accept;
   logic [0:NIB_W-1]   nibble;
   logic               corrected;

   hamming74_correct u_correct (
      .cw        (cw_in),
      .nibble    (nibble),
      .corrected (corrected)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      word_d     = word_q;
      corr_d     = corr_q;
      cw_ready   = rdy_q && (state_q == COLLECT);
      word_valid = (state_q == HOLD);
      accept     = cw_valid && cw_ready;

      unique case (state_q)
         COLLECT: begin
            if (sync) begin
               cnt_d = '0;
               err_d = 1'b0;
            end
            if (accept) begin
               word_d = {nibble, word_q[0:WORD_W-NIB_W-1]};
               // A sync-accept starts a fresh word, so its nibble is counted as the first.
               if (sync || (cnt_q == '0)) begin
                  err_d = corrected;
               end else begin
                  err_d = err_q | corrected;
               end
               if (sync) begin
                  cnt_d = CNT_W'(1);
               end else if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (corrected && (corr_q != 8'hFF)) begin
                  corr_d = corr_q + 8'd1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
         corr_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         word_q  <= word_d;
         corr_q  <= corr_d;
         rdy_q   <= 1'b1;
      end
   end

   assign word_out = word_q;
   assign word_err = err_q;
   assign corr_cnt = corr_q;

endmodule
